instruction_fetch_memory: RTL and testbench
===========================================

# instruction_fetch_memory

Parametrised, byte-addressed, little-endian instruction memory with a valid/ready fetch port, a registered one-deep response stage with backpressure, a byte-wide program-load port and an accepted-fetch counter. It sits between the PC/fetch stage and decode. It replaces the combinational instruction ROM with a synchronous, stallable fetch path that can be reloaded at run time.

## Interface
Parameters:
- DEPTH_BYTES, 64: memory size in bytes; must be a power of two and at least 16.
- ADDR_WIDTH, 64: width of fetch and load addresses.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset.
- Req_Valid  input  1  fetch request present.
- Req_Ready  output  1  fetch request can be accepted this cycle.
- Inst_Address  input  ADDR_WIDTH  byte address of the fetch; sampled on request acceptance.
- Rsp_Valid  output  1  Instruction is valid.
- Rsp_Ready  input  1  consumer takes the response.
- Instruction  output  32  fetched word: byte A in [7:0] through byte A+3 in [31:24].
- Fault  output  1  response came from a misaligned or out-of-range address; qualified by Rsp_Valid.
- Load_En  input  1  program-load byte write this cycle.
- Load_Addr  input  ADDR_WIDTH  byte address of the load write.
- Load_Data  input  8  byte to write.
- Fetch_Count  output  32  number of accepted fetch requests.

## Operation
- Storage is DEPTH_BYTES x 8 bits. Reset does not clear it.
- Power-up image, little-endian:
  - word 0 = 0x0F053483
  - word 4 = 0x009A84B3
  - word 8 = 0x00148493
  - word 12 = 0x0E953823
  - all other bytes 0x00.
- Accept: a request is accepted when Req_Valid && Req_Ready.
  - Req_Ready = !Load_En && (!Rsp_Valid || Rsp_Ready).
- On acceptance, bytes A..A+3 are read, assembled and registered into Instruction. Rsp_Valid is set and Fault is computed.
- Response state machine:
  - EMPTY: Rsp_Valid=0. Goes to FULL on accept.
  - FULL: Rsp_Valid=1. Goes to EMPTY when Rsp_Ready=1 and no new accept. Stays FULL with new data when Rsp_Ready=1 and a new accept occurs in the same cycle. Holds when Rsp_Ready=0.
- While FULL with Rsp_Ready=0, Instruction and Fault are held stable.
- Load write: when Load_En=1, memory[Load_Addr mod DEPTH_BYTES] <= Load_Data at the clock edge.
  - A held response keeps its captured value even if a load overwrites its source bytes.
- Load_En blocks fetch acceptance. A fetch accepted in the cycle after the last load byte sees the new data.
- Fetch_Count increments by 1 per accept and wraps from 0xFFFFFFFF to 0.

## Timing
- Latency: accept in cycle N gives Rsp_Valid=1 with data in cycle N+1.
- Throughput: one fetch per cycle when Rsp_Ready is held high.
- Reset asserted, at any time and asynchronously:
  - Rsp_Valid=0, Instruction=0x00000000, Fault=0, Fetch_Count=0.
  - State returns to EMPTY and any pending response is discarded.
  - Req_Ready follows its equation, so it is 1 unless Load_En=1.
- Outputs are meaningful only while reset is deasserted.
- Req_Ready is combinational from Load_En, Rsp_Valid and Rsp_Ready. It has no dependence on Req_Valid.

## Configuration
- IMEM_FAULT_EN defined:
  - Fault=1 when Inst_Address[1:0]!=0 or Inst_Address > DEPTH_BYTES-4.
  - A faulting response returns Instruction=0x00000013 (NOP) and the fetch does not read memory.
  - The fetch is still counted.
  - Load writes with Load_Addr >= DEPTH_BYTES are dropped.
- IMEM_FAULT_EN undefined:
  - Fault is tied to 0.
  - Each of the four byte addresses is taken modulo DEPTH_BYTES, so a fetch at DEPTH_BYTES-2 returns bytes DEPTH_BYTES-2, DEPTH_BYTES-1, 0, 1.
  - Misaligned fetches return the unaligned little-endian word.
  - Load addresses wrap modulo DEPTH_BYTES.

## Test plan
- Reset release, then fetch addresses 0, 4, 8, 12 back-to-back with Rsp_Ready=1: Instruction is 0x0F053483, 0x009A84B3, 0x00148493, 0x0E953823 in consecutive cycles starting one cycle after the first accept, and Fetch_Count=4.
- Fetch 4 with Rsp_Ready=0 for 3 cycles: Rsp_Valid=1, Instruction stable at 0x009A84B3 and Req_Ready=0. When Rsp_Ready rises, a second fetch to 8 is accepted in the same cycle.
- Load bytes 0x13,0x00,0x00,0x00 into addresses 16..19 with Req_Valid=1 throughout: Req_Ready=0 during the load. The next fetch at 16 returns 0x00000013.
- With IMEM_FAULT_EN, fetch 2 and fetch DEPTH_BYTES: both give Fault=1 and Instruction=0x00000013. Without the macro, fetch 2 returns 0x84B30F05 and Fault=0.
- Assert reset for one cycle while a response is held: Rsp_Valid=0 immediately and Fetch_Count=0. Memory image is retained, so a fetch at 0 after reset returns 0x0F053483.
- Run 100 random accept/backpressure cycles against a scoreboard: every accepted address has exactly one response, in order, and none is lost or duplicated.

Source files
------------

// File: rtl/instruction_fetch_memory.sv
// Byte-addressed little-endian instruction memory with a valid/ready fetch port,
// one-deep registered response, byte program-load port and fetch counter.
// Optional IMEM_FAULT_EN: misaligned/out-of-range fetches return a faulting NOP.
module instruction_fetch_memory #(
  parameter int unsigned DEPTH_BYTES = 64,
  parameter int unsigned ADDR_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Req_Valid,
  output logic                  Req_Ready,
  input  logic [ADDR_WIDTH-1:0] Inst_Address,
  output logic                  Rsp_Valid,
  input  logic                  Rsp_Ready,
  output logic [31:0]           Instruction,
  output logic                  Fault,
  input  logic                  Load_En,
  input  logic [ADDR_WIDTH-1:0] Load_Addr,
  input  logic [7:0]            Load_Data,
  output logic [31:0]           Fetch_Count
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [127:0] IMAGE = {32'h0E95_3823, 32'h0014_8493,
                                    32'h009A_84B3, 32'h0F05_3483};

  typedef logic [7:0] mem_t [DEPTH_BYTES];

  function automatic mem_t power_up_image();
    mem_t img;
    img = '{default: '0};
    for (int unsigned i = 0; i < 16; i++) begin
      img[IDX_W'(i)] = IMAGE[i*8 +: 8];
    end
    return img;
  endfunction

  // Contents survive reset; only the power-up image is preset.
  mem_t mem_q = power_up_image();

  logic [0:0]       state_q, state_d;
  logic [31:0]      inst_q, inst_d;
  logic             fault_q, fault_d;
  logic [31:0]      count_q, count_d;

  logic             rsp_valid;
  logic             accept;
  logic             addr_fault;
  logic             wr_ok;
  logic             mem_we;
  logic [IDX_W-1:0] mem_waddr;
  logic [IDX_W-1:0] base;
  logic [31:0]      fetch_word;

`ifdef IMEM_FAULT_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(DEPTH_BYTES - 4);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_ADDR = ADDR_WIDTH'(DEPTH_BYTES);

  always_comb begin
    addr_fault = (Inst_Address[1:0] != 2'b00) || (Inst_Address > LAST_WORD);
    wr_ok      = (Load_Addr < DEPTH_ADDR);
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{Inst_Address[ADDR_WIDTH-1:IDX_W],
                              Load_Addr[ADDR_WIDTH-1:IDX_W]};

  always_comb begin
    addr_fault = 1'b0;
    wr_ok      = 1'b1;
  end
`endif

  assign rsp_valid = (state_q == ST_FULL);
  assign Req_Ready = !Load_En && (!rsp_valid || Rsp_Ready);
  assign accept    = Req_Valid && Req_Ready;

  // Byte indices wrap naturally in IDX_W bits, giving modulo-depth reads.
  always_comb begin
    base       = Inst_Address[IDX_W-1:0];
    fetch_word = {mem_q[base + IDX_W'(3)], mem_q[base + IDX_W'(2)],
                  mem_q[base + IDX_W'(1)], mem_q[base]};
  end

  always_comb begin
    state_d = state_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    count_d = count_q;
    if (accept) begin
      state_d = ST_FULL;
      inst_d  = addr_fault ? NOP : fetch_word;
      fault_d = addr_fault;
      count_d = count_q + 32'd1;
    end else if (rsp_valid && Rsp_Ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_comb begin
    mem_we    = Load_En && wr_ok;
    mem_waddr = Load_Addr[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= Load_Data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_EMPTY;
      inst_q  <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      fault_q <= fault_d;
      count_q <= count_d;
    end
  end

  assign Rsp_Valid   = rsp_valid;
  assign Instruction = inst_q;
  assign Fault       = fault_q;
  assign Fetch_Count = count_q;

endmodule

// File: tb/tb_instruction_fetch_memory.sv
// Bench for instruction_fetch_memory: directed scenarios plus a randomized
// run checked against a byte-array memory model and an in-order response queue.
module tb_instruction_fetch_memory;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_v;
  logic          req_rdy;
  logic [AW-1:0] addr;
  logic          rsp_v;
  logic          rsp_rdy;
  logic [31:0]   inst;
  logic          fault;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic [31:0]   cnt;

  instruction_fetch_memory #(.DEPTH_BYTES(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .Req_Valid(req_v), .Req_Ready(req_rdy), .Inst_Address(addr),
    .Rsp_Valid(rsp_v), .Rsp_Ready(rsp_rdy), .Instruction(inst), .Fault(fault),
    .Load_En(ld_en), .Load_Addr(ld_addr), .Load_Data(ld_data),
    .Fetch_Count(cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: memory bytes, pending responses {fault, word}, accept count.
  logic [7:0]  m_mem [DEPTH];
  logic [32:0] sbq [$];
  logic [31:0] m_count;

  function automatic logic [32:0] ref_fetch(input logic [AW-1:0] a);
    int unsigned b;
`ifdef IMEM_FAULT_EN
    if ((a % 4) != 0 || a > DEPTH - 4) return {1'b1, 32'h0000_0013};
`endif
    b = int'(a % DEPTH);
    return {1'b0, m_mem[(b + 3) % DEPTH], m_mem[(b + 2) % DEPTH],
            m_mem[(b + 1) % DEPTH], m_mem[b]};
  endfunction

  task automatic model_init();
    logic [31:0] img [4];
    img = '{32'h0F053483, 32'h009A84B3, 32'h00148493, 32'h0E953823};
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    for (int w = 0; w < 4; w++)
      for (int k = 0; k < 4; k++) m_mem[w*4 + k] = 8'((img[w] >> (8*k)) & 32'hFF);
  endtask

  // Advance the model by one clock using the currently driven inputs, then step.
  task automatic tick();
    bit          m_valid;
    bit          acc;
    logic [32:0] r;
    m_valid = (sbq.size() != 0);
    acc     = req_v && !ld_en && (!m_valid || rsp_rdy);
    r       = ref_fetch(addr);
    if (ld_en) begin
`ifdef IMEM_FAULT_EN
      if (ld_addr < DEPTH) m_mem[ld_addr % DEPTH] = ld_data;
`else
      m_mem[ld_addr % DEPTH] = ld_data;
`endif
    end
    if (m_valid && rsp_rdy) void'(sbq.pop_front());
    if (acc) begin
      sbq.push_back(r);
      m_count = m_count + 32'd1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_v = 1'b0; rsp_rdy = 1'b0; ld_en = 1'b0;
    addr = '0; ld_addr = '0; ld_data = '0;
    sbq.delete(); m_count = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_v); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL reset_instruction got %h want 00000000", inst); end
    tests++; if (fault !== 1'b0) begin fails++; $display("FAIL reset_fault got %b want 0", fault); end
    tests++; if (cnt !== 32'h0) begin fails++; $display("FAIL reset_count got %0d want 0", cnt); end
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset_req_ready got %b want 1", req_rdy); end
    ld_en = 1'b1; #1;
    tests++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL reset_req_ready_load got %b want 0", req_rdy); end
    ld_en = 1'b0; #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    exp_w = '{32'h0F053483, 32'h009A84B3, 32'h00148493, 32'h0E953823};
    rsp_rdy = 1'b1; req_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = AW'(4 * i);
      #1;
      tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d] got %b want 1", i, req_rdy); end
      tick();
      tests++; if (rsp_v !== 1'b1 || inst !== exp_w[i] || fault !== 1'b0) begin
        fails++; $display("FAIL b2b_word[%0d] got v=%b %h f=%b want v=1 %h f=0", i, rsp_v, inst, fault, exp_w[i]);
      end
    end
    req_v = 1'b0;
    tests++; if (cnt !== 32'd4) begin fails++; $display("FAIL b2b_count got %0d want 4", cnt); end
    tick();
    tests++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b want 0", rsp_v); end
  endtask

  task automatic test_backpressure();
    rsp_rdy = 1'b0; req_v = 1'b1; addr = 64'd4;
    #1; tick();
    tests++; if (rsp_v !== 1'b1 || inst !== 32'h009A84B3) begin
      fails++; $display("FAIL bp_first got v=%b %h want v=1 009a84b3", rsp_v, inst);
    end
    addr = 64'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL bp_ready_low[%0d] got %b want 0", i, req_rdy); end
      tick();
      tests++; if (rsp_v !== 1'b1 || inst !== 32'h009A84B3) begin
        fails++; $display("FAIL bp_hold[%0d] got v=%b %h want v=1 009a84b3", i, rsp_v, inst);
      end
    end
    rsp_rdy = 1'b1; #1;
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL bp_ready_release got %b want 1", req_rdy); end
    tick();
    tests++; if (rsp_v !== 1'b1 || inst !== 32'h00148493) begin
      fails++; $display("FAIL bp_second got v=%b %h want v=1 00148493", rsp_v, inst);
    end
    tests++; if (cnt !== m_count) begin fails++; $display("FAIL bp_count got %0d want %0d", cnt, m_count); end
    req_v = 1'b0; tick();
  endtask

  task automatic test_load();
    logic [7:0] bytes_in [4];
    bytes_in = '{8'h13, 8'h00, 8'h00, 8'h00};
    rsp_rdy = 1'b1; req_v = 1'b1; addr = 64'd16;
    for (int i = 0; i < 4; i++) begin
      ld_en = 1'b1; ld_addr = AW'(16 + i); ld_data = bytes_in[i];
      #1;
      tests++; if (req_rdy !== 1'b0) begin fails++; $display("FAIL load_ready[%0d] got %b want 0", i, req_rdy); end
      tick();
      tests++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL load_no_accept[%0d] got %b want 0", i, rsp_v); end
    end
    ld_en = 1'b0; #1;
    tick();
    tests++; if (rsp_v !== 1'b1 || inst !== 32'h00000013) begin
      fails++; $display("FAIL load_fetch got v=%b %h want v=1 00000013", rsp_v, inst);
    end
    req_v = 1'b0; tick();
  endtask

  task automatic test_misaligned();
    logic [32:0] want;
    rsp_rdy = 1'b1; req_v = 1'b1; addr = 64'd2;
    #1; tick();
`ifdef IMEM_FAULT_EN
    want = {1'b1, 32'h00000013};
`else
    want = {1'b0, 32'h84B30F05};
`endif
    tests++; if ({fault, inst} !== want || rsp_v !== 1'b1) begin
      fails++; $display("FAIL misaligned_2 got f=%b %h want f=%b %h", fault, inst, want[32], want[31:0]);
    end
`ifdef IMEM_FAULT_EN
    addr = AW'(DEPTH);
    want = {1'b1, 32'h00000013};
`else
    addr = AW'(DEPTH - 2);
    want = {1'b0, 32'h34830000};
`endif
    #1; tick();
    tests++; if ({fault, inst} !== want || {fault, inst} !== sbq[0]) begin
      fails++; $display("FAIL edge_addr got f=%b %h want f=%b %h", fault, inst, want[32], want[31:0]);
    end
    req_v = 1'b0; tick();
  endtask

  task automatic test_reset_held();
    rsp_rdy = 1'b0; req_v = 1'b1; addr = 64'd0;
    #1; tick();
    req_v = 1'b0;
    tests++; if (rsp_v !== 1'b1) begin fails++; $display("FAIL held_before_reset got %b want 1", rsp_v); end
    #2; reset = 1'b0; #1;
    sbq.delete(); m_count = '0;
    tests++; if (rsp_v !== 1'b0) begin fails++; $display("FAIL async_reset_valid got %b want 0", rsp_v); end
    tests++; if (cnt !== 32'h0) begin fails++; $display("FAIL async_reset_count got %0d want 0", cnt); end
    tests++; if (inst !== 32'h0) begin fails++; $display("FAIL async_reset_inst got %h want 00000000", inst); end
    @(posedge clk); #1;
    reset = 1'b1; req_v = 1'b1; rsp_rdy = 1'b1; addr = 64'd0;
    #1; tick();
    tests++; if (inst !== 32'h0F053483 || cnt !== 32'd1) begin
      fails++; $display("FAIL after_reset_fetch got %h cnt=%0d want 0f053483 cnt=1", inst, cnt);
    end
    req_v = 1'b0; tick();
  endtask

  task automatic test_random();
    bit exp_rdy;
    for (int i = 0; i < 100; i++) begin
      req_v   = ($urandom_range(3) != 0);
      rsp_rdy = ($urandom_range(2) != 0);
      addr    = ($urandom_range(7) == 0) ? AW'($urandom_range(DEPTH + 8))
                                         : AW'(4 * $urandom_range(DEPTH / 4 - 1));
      ld_en   = ($urandom_range(9) == 0);
      ld_addr = AW'($urandom_range(DEPTH + 7));
      ld_data = 8'($urandom);
      #1;
      exp_rdy = !ld_en && (sbq.size() == 0 || rsp_rdy);
      tests++; if (req_rdy !== exp_rdy) begin fails++; $display("FAIL rand_ready[%0d] got %b want %b", i, req_rdy, exp_rdy); end
      tests++; if (rsp_v !== (sbq.size() != 0)) begin
        fails++; $display("FAIL rand_valid[%0d] got %b want %b", i, rsp_v, sbq.size() != 0);
      end
      if (sbq.size() != 0) begin
        tests++; if ({fault, inst} !== sbq[0]) begin
          fails++; $display("FAIL rand_rsp[%0d] got f=%b %h want f=%b %h", i, fault, inst, sbq[0][32], sbq[0][31:0]);
        end
      end
      tick();
    end
    req_v = 1'b0; ld_en = 1'b0; rsp_rdy = 1'b1;
    #1; tick();
    tests++; if (rsp_v !== 1'b0 || sbq.size() != 0) begin
      fails++; $display("FAIL rand_drain got v=%b pending=%0d want v=0 pending=0", rsp_v, sbq.size());
    end
    tests++; if (cnt !== m_count) begin fails++; $display("FAIL rand_count got %0d want %0d", cnt, m_count); end
  endtask

  initial begin
    model_init();
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_load();
    test_misaligned();
    test_reset_held();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
